// File: rtl/if_stage_ctrl_pkg.sv
// Shared encodings for the fetch-stage controller: redirect selects, FSM states,
// the injected bubble word and the redirect counter helper.
package if_stage_ctrl_pkg;

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        TNP_NONE = 2'b00,
        TNP_BEQ  = 2'b01,
        TNP_JMP  = 2'b10,
        TNP_JR   = 2'b11
    } tnp_e;

    typedef enum logic {
        ST_RUN        = 1'b0,
        ST_REDIR_WAIT = 1'b1
    } state_e;

    // sll $0,$0,0
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/if_stage_ctrl_next_pc_mux.sv
// Redirect target select; an undefined or idle select falls back to pc4.
module next_pc_mux
    import if_stage_ctrl_pkg::*;
#(
    parameter int unsigned PC_WIDTH = 32
) (
    input  logic [1:0]          i_takenewpc,
    input  logic                i_branch_taken,
    input  logic [PC_WIDTH-1:0] i_pc4,
    input  logic [PC_WIDTH-1:0] i_branch_target,
    input  logic [PC_WIDTH-1:0] i_jump_target,
    input  logic [PC_WIDTH-1:0] i_jr_target,
    output logic [PC_WIDTH-1:0] o_target
);

    always_comb begin
        o_target = i_pc4;
        case (i_takenewpc)
            TNP_BEQ: o_target = i_branch_taken ? i_branch_target : i_pc4;
            TNP_JMP: o_target = i_jump_target;
            TNP_JR:  o_target = i_jr_target;
            default: o_target = i_pc4;
        endcase
    end

endmodule

// File: rtl/if_stage_ctrl.sv
// Fetch-stage controller: PC register, one-shot redirect FSM, IF/ID register
// and saturating redirect counter.
module if_stage_ctrl #(
    parameter int unsigned            PC_WIDTH   = 32,
    parameter int unsigned            INST_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]    RESET_PC   = 32'h0000_0000,
    parameter logic [INST_WIDTH-1:0]  NOP_WORD   = INST_WIDTH'(if_stage_ctrl_pkg::NOP_WORD)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stoppc,
    input  logic                  holdreg,
    input  logic [1:0]            takenewpc,
    input  logic                  branch_taken,
    input  logic [PC_WIDTH-1:0]   branch_target,
    input  logic [PC_WIDTH-1:0]   jump_target,
    input  logic [PC_WIDTH-1:0]   jr_target,
    output logic [PC_WIDTH-1:0]   imem_addr,
    input  logic [INST_WIDTH-1:0] imem_rdata,
    output logic [INST_WIDTH-1:0] ifid_inst,
    output logic [PC_WIDTH-1:0]   ifid_pc4,
    output logic                  ifid_valid,
    output logic [15:0]           redirect_cnt
);

    import if_stage_ctrl_pkg::*;

    state_e                  r_state, w_state_nxt;
    logic [PC_WIDTH-1:0]     r_pc, w_pc_nxt;
    logic [INST_WIDTH-1:0]   r_ifid_inst, w_ifid_inst_nxt;
    logic [PC_WIDTH-1:0]     r_ifid_pc4, w_ifid_pc4_nxt;
    logic                    r_ifid_valid, w_ifid_valid_nxt;
    logic [CNT_W-1:0]        r_redirect_cnt, w_redirect_cnt_nxt;
    logic [PC_WIDTH-1:0]     w_pc4;
    logic [PC_WIDTH-1:0]     w_target;

    assign w_pc4 = r_pc + PC_WIDTH'(4);

    next_pc_mux #(
        .PC_WIDTH (PC_WIDTH)
    ) u_next_pc_mux (
        .i_takenewpc     (takenewpc),
        .i_branch_taken  (branch_taken),
        .i_pc4           (w_pc4),
        .i_branch_target (branch_target),
        .i_jump_target   (jump_target),
        .i_jr_target     (jr_target),
        .o_target        (w_target)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_RUN;
            r_pc           <= RESET_PC;
            r_ifid_inst    <= NOP_WORD;
            r_ifid_pc4     <= '0;
            r_ifid_valid   <= 1'b0;
            r_redirect_cnt <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_pc           <= w_pc_nxt;
            r_ifid_inst    <= w_ifid_inst_nxt;
            r_ifid_pc4     <= w_ifid_pc4_nxt;
            r_ifid_valid   <= w_ifid_valid_nxt;
            r_redirect_cnt <= w_redirect_cnt_nxt;
        end
    end

    // Redirect is taken once on entry to REDIR_WAIT; the hold there absorbs
    // the remaining cycles of the hazard unit's takenewpc assertion.
    always_comb begin
        w_state_nxt        = r_state;
        w_pc_nxt           = r_pc;
        w_ifid_inst_nxt    = r_ifid_inst;
        w_ifid_pc4_nxt     = r_ifid_pc4;
        w_ifid_valid_nxt   = r_ifid_valid;
        w_redirect_cnt_nxt = r_redirect_cnt;

        case (r_state)
            ST_RUN: begin
                if (takenewpc != TNP_NONE) begin
                    w_pc_nxt           = w_target;
                    w_ifid_inst_nxt    = NOP_WORD;
                    w_ifid_valid_nxt   = 1'b0;
                    w_redirect_cnt_nxt = sat_inc(r_redirect_cnt);
                    w_state_nxt        = ST_REDIR_WAIT;
                end else begin
                    if (!stoppc) begin
                        w_pc_nxt = w_pc4;
                    end
                    if (!holdreg) begin
                        if (stoppc) begin
                            w_ifid_inst_nxt  = NOP_WORD;
                            w_ifid_valid_nxt = 1'b0;
                        end else begin
                            w_ifid_inst_nxt  = imem_rdata;
                            w_ifid_pc4_nxt   = w_pc4;
                            w_ifid_valid_nxt = 1'b1;
                        end
                    end
                end
            end
            ST_REDIR_WAIT: begin
                if (!holdreg) begin
                    w_ifid_inst_nxt  = NOP_WORD;
                    w_ifid_valid_nxt = 1'b0;
                end
                if (takenewpc == TNP_NONE) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    assign imem_addr    = r_pc;
    assign ifid_inst    = r_ifid_inst;
    assign ifid_pc4     = r_ifid_pc4;
    assign ifid_valid   = r_ifid_valid;
    assign redirect_cnt = r_redirect_cnt;

endmodule

// File: tb/tb_if_stage_ctrl.sv
// Directed bench for if_stage_ctrl: each vector queues its hand-computed
// expected outputs, a separate monitor pops and compares them.
module tb_if_stage_ctrl;

    logic        clk;
    logic        rst_n;
    logic        stoppc;
    logic        holdreg;
    logic [1:0]  takenewpc;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] jr_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] ifid_inst;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic [15:0] redirect_cnt;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] pc4;
        logic        valid;
        logic [15:0] cnt;
        bit          chk_pc4;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    event chk_ev;

    if_stage_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stoppc        (stoppc),
        .holdreg       (holdreg),
        .takenewpc     (takenewpc),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump_target   (jump_target),
        .jr_target     (jr_target),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .ifid_inst     (ifid_inst),
        .ifid_pc4      (ifid_pc4),
        .ifid_valid    (ifid_valid),
        .redirect_cnt  (redirect_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: word tagged with its own address.
    assign imem_rdata = {16'hC0DE, imem_addr[15:0]};

    always begin : monitor
        exp_t e;
        @(negedge clk or chk_ev);
        while (q.size() > 0) begin
            e = q.pop_front();
            n_vec++;
            if (imem_addr !== e.pc || ifid_inst !== e.inst || ifid_valid !== e.valid ||
                redirect_cnt !== e.cnt || (e.chk_pc4 && ifid_pc4 !== e.pc4)) begin
                n_miss++;
                $display("FAIL %s: got pc=%h inst=%h pc4=%h valid=%b cnt=%0d, want pc=%h inst=%h pc4=%h valid=%b cnt=%0d",
                         e.name, imem_addr, ifid_inst, ifid_pc4, ifid_valid, redirect_cnt,
                         e.pc, e.inst, e.pc4, e.valid, e.cnt);
            end
        end
    end

    task automatic push(input string nm, input logic [31:0] epc, input logic [31:0] einst,
                        input logic [31:0] epc4, input logic ev, input logic [15:0] ec,
                        input bit c4);
        exp_t e;
        e.name = nm; e.pc = epc; e.inst = einst; e.pc4 = epc4;
        e.valid = ev; e.cnt = ec; e.chk_pc4 = c4;
        q.push_back(e);
    endtask

    // Drive one cycle of hazard inputs and queue the state expected after the edge.
    task automatic step(input string nm, input logic s, input logic h, input logic [1:0] t,
                        input logic [31:0] epc, input logic [31:0] einst,
                        input logic [31:0] epc4, input logic ev, input logic [15:0] ec,
                        input bit c4);
        stoppc    = s;
        holdreg   = h;
        takenewpc = t;
        @(posedge clk);
        #1;
        push(nm, epc, einst, epc4, ev, ec, c4);
    endtask

    initial begin
        rst_n         = 1'b0;
        stoppc        = 1'b0;
        holdreg       = 1'b0;
        takenewpc     = 2'b00;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        jump_target   = 32'h0;
        jr_target     = 32'h0;

        #1;
        push("reset", 32'h0, 32'h0, 32'h0, 1'b0, 16'd0, 1'b1);
        -> chk_ev;
        @(negedge clk);
        #2 rst_n = 1'b1;

        step("run0",   0, 0, 2'b00, 32'h4,  32'hC0DE_0000, 32'h4,  1, 16'd0, 1);
        step("run1",   0, 0, 2'b00, 32'h8,  32'hC0DE_0004, 32'h8,  1, 16'd0, 1);
        step("stall0", 1, 1, 2'b00, 32'h8,  32'hC0DE_0004, 32'h8,  1, 16'd0, 1);
        step("stall1", 1, 1, 2'b00, 32'h8,  32'hC0DE_0004, 32'h8,  1, 16'd0, 1);
        step("stall2", 1, 1, 2'b00, 32'h8,  32'hC0DE_0004, 32'h8,  1, 16'd0, 1);
        step("release",0, 0, 2'b00, 32'hC,  32'hC0DE_0008, 32'hC,  1, 16'd0, 1);
        step("run2",   0, 0, 2'b00, 32'h10, 32'hC0DE_000C, 32'h10, 1, 16'd0, 1);

        jump_target = 32'h40;
        step("jmp",       0, 0, 2'b10, 32'h40, 32'h0, 32'h0, 0, 16'd1, 0);
        step("jmp_held",  0, 0, 2'b10, 32'h40, 32'h0, 32'h0, 0, 16'd1, 0);
        step("jmp_wait",  0, 0, 2'b00, 32'h40, 32'h0, 32'h0, 0, 16'd1, 0);
        step("jmp_fetch", 0, 0, 2'b00, 32'h44, 32'hC0DE_0040, 32'h44, 1, 16'd1, 1);
        step("jmp_seq",   0, 0, 2'b00, 32'h48, 32'hC0DE_0044, 32'h48, 1, 16'd1, 1);

        branch_taken  = 1'b0;
        branch_target = 32'h200;
        step("beq_nt",      0, 0, 2'b01, 32'h4C, 32'h0, 32'h0, 0, 16'd2, 0);
        step("beq_nt_wait", 0, 0, 2'b00, 32'h4C, 32'h0, 32'h0, 0, 16'd2, 0);
        step("beq_nt_seq",  0, 0, 2'b00, 32'h50, 32'hC0DE_004C, 32'h50, 1, 16'd2, 1);

        branch_taken  = 1'b1;
        branch_target = 32'h80;
        step("beq_t_flush_over_hold", 0, 1, 2'b01, 32'h80, 32'h0, 32'h0, 0, 16'd3, 0);
        jr_target = 32'h1234;
        step("redir_change_ignored",  0, 1, 2'b11, 32'h80, 32'h0, 32'h0, 0, 16'd3, 0);
        step("beq_t_wait_stop",       1, 0, 2'b00, 32'h80, 32'h0, 32'h0, 0, 16'd3, 0);
        step("beq_t_fetch",           0, 0, 2'b00, 32'h84, 32'hC0DE_0080, 32'h84, 1, 16'd3, 1);
        step("stop_bubble",           1, 0, 2'b00, 32'h84, 32'h0, 32'h0, 0, 16'd3, 0);
        step("stop_release",          0, 0, 2'b00, 32'h88, 32'hC0DE_0084, 32'h88, 1, 16'd3, 1);
        step("hold_only",             0, 1, 2'b00, 32'h8C, 32'hC0DE_0084, 32'h88, 1, 16'd3, 1);

        jr_target = 32'hFFFF_FFFC;
        step("jr",        0, 0, 2'b11, 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 16'd4, 0);
        step("jr_wait",   0, 0, 2'b00, 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 16'd4, 0);
        step("wrap",      0, 0, 2'b00, 32'h0, 32'hC0DE_FFFC, 32'h0, 1, 16'd4, 1);
        step("post_wrap", 0, 0, 2'b00, 32'h4, 32'hC0DE_0000, 32'h4, 1, 16'd4, 1);

        jump_target = 32'h40;
        step("jmp2", 0, 0, 2'b10, 32'h40, 32'h0, 32'h0, 0, 16'd5, 0);
        @(negedge clk);
        #1;
        rst_n     = 1'b0;
        takenewpc = 2'b00;
        #1;
        push("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 16'd0, 1'b1);
        -> chk_ev;
        @(posedge clk);
        #2 rst_n = 1'b1;
        step("rst_run", 0, 0, 2'b00, 32'h4, 32'hC0DE_0000, 32'h4, 1, 16'd0, 1);

        @(negedge clk);
        #1;
        n_vec++;
        if (q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
